// File: rtl/aes_spi_job_sequencer.sv
// AES job sequencer: key frame, block frame and readback over SPI_Main, with a valid/ready job interface.
// Defining AES_SEQ_KEY_CACHE_EN adds a per-slave key cache that skips the key frame on a match.
`timescale 1ns/1ps
module aes_spi_job_sequencer #(
    parameter int unsigned GAP_CYCLES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_sel,
    input  logic [1:0]   req_key_len,
    input  logic [255:0] req_key,
    input  logic [127:0] req_data,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [127:0] rsp_data,
    output logic         rsp_err,
    output logic         spi_start,
    output logic         spi_sel,
    output logic [0:257] spi_tx,
    input  logic [0:127] spi_rx,
    input  logic         spi_done,
    output logic         busy
);
    localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_KEY_GO, S_KEY_WAIT, S_GAP, S_MSG_GO, S_MSG_WAIT, S_RD_GO, S_RD_WAIT, S_RESP
    } state_e;

    state_e          state_q, state_d, gap_tgt_q, gap_tgt_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic            seen_low_q, seen_low_d;
    logic            sel_q, sel_d;
    logic [127:0]    data_q, data_d;
    logic            rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [127:0]    rsp_data_q, rsp_data_d;
    logic            spi_start_q, spi_start_d, spi_sel_q, spi_sel_d;
    logic [0:257]    spi_tx_q, spi_tx_d;
    logic            cache_hit;

    function automatic logic [255:0] norm_key(input logic [1:0] len, input logic [255:0] key);
        case (len)
            2'b00:   norm_key = {128'b0, key[127:0]};
            2'b01:   norm_key = {64'b0, key[191:0]};
            default: norm_key = key;
        endcase
    endfunction

`ifdef AES_SEQ_KEY_CACHE_EN
    logic [1:0]             len_q, len_d;
    logic [255:0]           key_q, key_d;
    logic [1:0]             c_vld_q, c_vld_d;
    logic [1:0][1:0]        c_len_q, c_len_d;
    logic [1:0][255:0]      c_key_q, c_key_d;

    assign cache_hit = c_vld_q[req_sel] && (c_len_q[req_sel] == req_key_len) &&
                       (c_key_q[req_sel] == norm_key(req_key_len, req_key));
`else
    assign cache_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        gap_tgt_d   = gap_tgt_q;
        gap_d       = gap_q;
        tmr_d       = tmr_q;
        seen_low_d  = seen_low_q;
        sel_d       = sel_q;
        data_d      = data_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_data_d  = rsp_data_q;
        spi_start_d = 1'b0;
        spi_sel_d   = spi_sel_q;
        spi_tx_d    = spi_tx_q;
`ifdef AES_SEQ_KEY_CACHE_EN
        len_d   = len_q;
        key_d   = key_q;
        c_vld_d = c_vld_q;
        c_len_d = c_len_q;
        c_key_d = c_key_q;
`endif
        // Timer and done-low qualifier run through every GO/WAIT cycle; launches below restart them.
        if (state_q inside {S_KEY_GO, S_KEY_WAIT, S_MSG_GO, S_MSG_WAIT, S_RD_GO, S_RD_WAIT}) begin
            tmr_d = tmr_q + TW'(1);
            if (!spi_done) seen_low_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: if (req_valid) begin
                sel_d  = req_sel;
                data_d = req_data;
`ifdef AES_SEQ_KEY_CACHE_EN
                len_d = req_key_len;
                key_d = norm_key(req_key_len, req_key);
`endif
                if (req_key_len == 2'b11) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_data_d  = '0;
`ifdef AES_SEQ_KEY_CACHE_EN
                    c_vld_d[req_sel] = 1'b0;
`endif
                end else begin
                    state_d     = cache_hit ? S_MSG_GO : S_KEY_GO;
                    spi_start_d = 1'b1;
                    spi_sel_d   = req_sel;
                    spi_tx_d    = cache_hit ? {2'b00, 128'b0, req_data}
                                            : {req_key_len, norm_key(req_key_len, req_key)};
                    tmr_d       = '0;
                    seen_low_d  = 1'b0;
                end
            end
            S_KEY_GO: state_d = S_KEY_WAIT;
            S_MSG_GO: state_d = S_MSG_WAIT;
            S_RD_GO:  state_d = S_RD_WAIT;
            S_KEY_WAIT, S_MSG_WAIT, S_RD_WAIT: begin
                if (spi_done && seen_low_q) begin
                    gap_d = '0;
                    if (state_q == S_KEY_WAIT) begin
                        state_d   = S_GAP;
                        gap_tgt_d = S_MSG_GO;
`ifdef AES_SEQ_KEY_CACHE_EN
                        c_vld_d[sel_q] = 1'b1;
                        c_len_d[sel_q] = len_q;
                        c_key_d[sel_q] = key_q;
`endif
                    end else if (state_q == S_MSG_WAIT) begin
                        state_d   = S_GAP;
                        gap_tgt_d = S_RD_GO;
                    end else begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b0;
                        rsp_data_d  = spi_rx;
                    end
                end else if (tmr_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_data_d  = '0;
`ifdef AES_SEQ_KEY_CACHE_EN
                    c_vld_d[sel_q] = 1'b0;
`endif
                end
            end
            S_GAP: begin
                gap_d = gap_q + GW'(1);
                if (gap_q == GW'(GAP_CYCLES - 1)) begin
                    state_d     = gap_tgt_q;
                    spi_start_d = 1'b1;
                    spi_sel_d   = sel_q;
                    spi_tx_d    = (gap_tgt_q == S_MSG_GO) ? {2'b00, 128'b0, data_q} : '0;
                    tmr_d       = '0;
                    seen_low_d  = 1'b0;
                end
            end
            S_RESP: if (rsp_ready) begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b0;
                rsp_err_d   = 1'b0;
                rsp_data_d  = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            gap_tgt_q   <= S_MSG_GO;
            gap_q       <= '0;
            tmr_q       <= '0;
            seen_low_q  <= 1'b0;
            sel_q       <= 1'b0;
            data_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            spi_start_q <= 1'b0;
            spi_sel_q   <= 1'b0;
            spi_tx_q    <= '0;
`ifdef AES_SEQ_KEY_CACHE_EN
            len_q   <= '0;
            key_q   <= '0;
            c_vld_q <= '0;
            c_len_q <= '0;
            c_key_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            gap_tgt_q   <= gap_tgt_d;
            gap_q       <= gap_d;
            tmr_q       <= tmr_d;
            seen_low_q  <= seen_low_d;
            sel_q       <= sel_d;
            data_q      <= data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
            spi_start_q <= spi_start_d;
            spi_sel_q   <= spi_sel_d;
            spi_tx_q    <= spi_tx_d;
`ifdef AES_SEQ_KEY_CACHE_EN
            len_q   <= len_d;
            key_q   <= key_d;
            c_vld_q <= c_vld_d;
            c_len_q <= c_len_d;
            c_key_q <= c_key_d;
`endif
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_data  = rsp_data_q;
    assign spi_start = spi_start_q;
    assign spi_sel   = spi_sel_q;
    assign spi_tx    = spi_tx_q;
endmodule

// File: tb/tb_aes_spi_job_sequencer.sv
// Self-checking bench for aes_spi_job_sequencer: directed known-answer jobs, illegal length,
// timeout, mid-job reset and random jobs against a frame/cache reference model.
`timescale 1ns/1ps
module tb_aes_spi_job_sequencer;
    localparam int unsigned G = 4;
    localparam int unsigned T = 64;
    localparam int unsigned BOUND = 400;
`ifdef AES_SEQ_KEY_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif
    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         rst, req_valid, req_ready, req_sel, rsp_valid, rsp_ready, rsp_err;
    logic [1:0]   req_key_len;
    logic [255:0] req_key;
    logic [127:0] req_data, rsp_data;
    logic         spi_start, spi_sel, spi_done, busy;
    logic [0:257] spi_tx;
    logic [0:127] spi_rx;

    aes_spi_job_sequencer #(.GAP_CYCLES(G), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
        .req_key_len(req_key_len), .req_key(req_key), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .spi_start(spi_start), .spi_sel(spi_sel), .spi_tx(spi_tx), .spi_rx(spi_rx),
        .spi_done(spi_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [257:0] obs, input logic [257:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] rand256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Slave-side model: logs every frame, answers after a random delay, sometimes leaves done stale-high.
    logic [257:0] frames[$];
    logic         sel_log[$];
    int unsigned  start_cyc[$];
    logic [257:0] cur_frame;
    logic [127:0] cur_result;
    bit           in_xfer = 0, hang = 0;
    int           hang_idx = -1, pend = 0, stale_n = 0;

    always @(negedge clk) begin
        if (!rst && in_xfer && !spi_start) chk("tx_stable", spi_tx, cur_frame);
        if (rst) begin
            pend = 0; stale_n = 0; spi_done = 1'b0; in_xfer = 0;
        end else if (spi_start) begin
            frames.push_back(spi_tx);
            sel_log.push_back(spi_sel);
            start_cyc.push_back(cyc);
            cur_frame = spi_tx;
            in_xfer   = 1;
            spi_rx    = {$urandom, $urandom, $urandom, $urandom};
            if (hang && (frames.size() - 1 == hang_idx)) begin
                pend = -1; stale_n = 0; spi_done = 1'b0;
            end else begin
                pend    = $urandom_range(1, 6);
                stale_n = (spi_done && $urandom_range(0, 1) == 1) ? $urandom_range(1, 2) : 0;
                if (stale_n == 0) spi_done = 1'b0;
            end
        end else if (stale_n > 0) begin
            stale_n--;
            if (stale_n == 0) spi_done = 1'b0;
        end else if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                spi_done = 1'b1;
                spi_rx   = (cur_frame == '0) ? cur_result : {$urandom, $urandom, $urandom, $urandom};
                in_xfer  = 0;
            end
        end else if (spi_done && $urandom_range(0, 1) == 0) begin
            spi_done = 1'b0;
        end
    end

    // Reference cache state: what each slave's entry should hold after each job.
    logic         mv[2];
    logic [1:0]   ml[2];
    logic [255:0] mk[2];

    task automatic run_job(input logic s, input logic [1:0] len, input logic [255:0] key,
                           input logic [127:0] data, input logic [127:0] result,
                           input int hidx, input string tag);
        logic [255:0] mask, nk;
        logic [257:0] ef[$];
        logic [127:0] exp_data;
        bit           legal, hit, exp_err;
        int unsigned  n, k;
        mask = (len == 2'b00) ? ((256'd1 << 128) - 1) : (len == 2'b01) ? ((256'd1 << 192) - 1) : '1;
        nk      = key & mask;
        legal   = (len != 2'b11);
        hit     = CACHE && mv[s] && (ml[s] == len) && (mk[s] == nk);
        exp_err = !legal || (hidx >= 0);
        if (legal) begin
            if (!hit) ef.push_back({len, nk});
            ef.push_back(258'(data));
            ef.push_back('0);
            while (hidx >= 0 && ef.size() > hidx + 1) void'(ef.pop_back());
        end
        exp_data = exp_err ? '0 : result;
        if (exp_err) mv[s] = 1'b0;
        else if (!hit) begin mv[s] = 1'b1; ml[s] = len; mk[s] = nk; end

        frames.delete(); sel_log.delete(); start_cyc.delete();
        hang = (hidx >= 0); hang_idx = hidx; cur_result = result;
        req_sel = s; req_key_len = len; req_key = key; req_data = data; req_valid = 1'b1;
        chk({tag, "_req_ready"}, req_ready, 1'b1);
        tick();
        req_valid = 1'b0; req_sel = ~s; req_key_len = 2'($urandom); req_key = rand256();
        req_data = {$urandom, $urandom, $urandom, $urandom};
        chk({tag, "_start_next"}, spi_start, legal);
        n = 0;
        while (!rsp_valid && n < BOUND) begin tick(); n++; end
        chk({tag, "_rsp_valid"}, rsp_valid, 1'b1);
        if (!legal) chk({tag, "_illegal_lat"}, n <= 1, 1'b1);
        chk({tag, "_n_starts"}, frames.size(), ef.size());
        if (hidx >= 0 && start_cyc.size() > hidx)
            chk({tag, "_timeout_lat"}, cyc - start_cyc[hidx], T);
        k = $urandom_range(0, 3);
        for (int unsigned i = 0; i < k; i++) begin
            tick();
            chk({tag, "_hold_valid"}, rsp_valid, 1'b1);
            chk({tag, "_hold_data"}, rsp_data, exp_data);
        end
        chk({tag, "_data"}, rsp_data, exp_data);
        chk({tag, "_err"}, rsp_err, exp_err);
        for (int i = 0; i < ef.size() && i < frames.size(); i++) begin
            chk($sformatf("%s_frame%0d", tag, i), frames[i], ef[i]);
            chk($sformatf("%s_sel%0d", tag, i), sel_log[i], s);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0; in_xfer = 0; hang = 0;
        chk({tag, "_idle_ready"}, req_ready, 1'b1);
        chk({tag, "_idle_busy"}, busy, 1'b0);
        chk({tag, "_rsp_drop"}, rsp_valid, 1'b0);
    endtask

    initial begin
        logic [255:0] k128, k192, k256, kr;
        logic [255:0] last_key[2];
        logic [1:0]   last_len[2], len;
        logic         s;
        int           hidx;
        int unsigned  n;
        rst = 1'b1; req_valid = 1'b0; req_sel = 1'b0; req_key_len = '0; req_key = '0; req_data = '0;
        rsp_ready = 1'b0; spi_done = 1'b0; spi_rx = '0;
        mv[0] = 1'b0; mv[1] = 1'b0;
        repeat (3) tick();
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, '0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_spi_start", spi_start, 1'b0);
        chk("rst_spi_sel", spi_sel, 1'b0);
        chk("rst_spi_tx", spi_tx, '0);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;
        tick();

        k128 = {$urandom, $urandom, $urandom, $urandom, 128'h000102030405060708090a0b0c0d0e0f};
        k192 = {$urandom, $urandom, 192'h000102030405060708090a0b0c0d0e0f1011121314151617};
        k256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        run_job(0, 2'b00, k128, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, PT, -1, "kat128");
        run_job(0, 2'b01, k192, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, PT, -1, "kat192");
        run_job(1, 2'b10, k256, 128'h8ea2b7ca516745bfeafc49904b496089, PT, -1, "kat256");
        run_job(1, 2'b10, k256, 128'h8ea2b7ca516745bfeafc49904b496089, PT, -1, "kat256_rep");
        run_job(1, 2'b11, k256, 128'h8ea2b7ca516745bfeafc49904b496089, PT, -1, "illegal");
        run_job(1, 2'b10, k256, 128'h8ea2b7ca516745bfeafc49904b496089, PT, -1, "post_illegal");
        run_job(0, 2'b00, k128, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, PT, -1, "warm128");
        run_job(0, 2'b00, k128, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, PT, 0, "timeout");
        run_job(0, 2'b00, k128, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, PT, -1, "post_timeout");

        // Reset while the message frame is in flight.
        frames.delete(); sel_log.delete(); start_cyc.delete();
        kr = rand256();
        cur_result = {$urandom, $urandom, $urandom, $urandom};
        req_sel = 1'b0; req_key_len = 2'b10; req_key = kr; req_data = 128'h1234; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        n = 0;
        while (frames.size() < 2 && n < BOUND) begin tick(); n++; end
        chk("rstmid_reach_msg", frames.size(), 2);
        rst = 1'b1;
        tick();
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_req_ready", req_ready, 1'b1);
        chk("rstmid_spi_start", spi_start, 1'b0);
        chk("rstmid_rsp_valid", rsp_valid, 1'b0);
        rst = 1'b0; in_xfer = 0; mv[0] = 1'b0; mv[1] = 1'b0;
        tick();
        run_job(0, 2'b10, kr, 128'h1234, {$urandom, $urandom, $urandom, $urandom}, -1, "after_rst");

        last_key[0] = k128; last_len[0] = 2'b00; last_key[1] = k256; last_len[1] = 2'b10;
        for (int unsigned j = 0; j < 24; j++) begin
            s = 1'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                kr = last_key[s]; len = last_len[s];
            end else begin
                kr = rand256(); n = $urandom_range(0, 9); len = (n == 9) ? 2'b11 : 2'(n % 3);
            end
            hidx = (len != 2'b11 && $urandom_range(0, 7) == 0) ? 0 : -1;
            if (len != 2'b11) begin last_key[s] = kr; last_len[s] = len; end
            run_job(s, len, kr, {$urandom, $urandom, $urandom, $urandom},
                    {$urandom, $urandom, $urandom, $urandom}, hidx, $sformatf("rnd%0d", j));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/aes_spi_job_sequencer.md
# aes_spi_job_sequencer

Sequences one AES job (key load, block load, result readback) over the existing `SPI_Main` master toward the two AES SPI slaves: slave 0 on `cs_n[0]`, slave 1 on `cs_n[1]`. It replaces the hand-timed start/wait sequence with a valid/ready job interface and done-driven transfers. It sits between the system front-end and `SPI_Main` and owns `SPI_Main`'s `start`, `sel` and `tx` inputs exclusively.

## Interface
- `GAP_CYCLES`, 4: idle clocks between consecutive SPI transfers of one job (min 1).
- `TIMEOUT_CYCLES`, 4096: max clocks from `spi_start` to `spi_done` before abort.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1 / `req_ready` out 1: job handshake; transfer on both high.
- `req_sel` in 1: target slave (0 → `cs_n[0]`, 1 → `cs_n[1]`).
- `req_key_len` in 2: 00 = 128, 01 = 192, 10 = 256, 11 = illegal.
- `req_key` in 256: key right-aligned (128-bit key in [127:0], upper bits ignored).
- `req_data` in 128: input block.
- `rsp_valid` out 1 / `rsp_ready` in 1: result handshake.
- `rsp_data` out 128: result block; 0 when `rsp_err`.
- `rsp_err` out 1: job aborted (timeout or illegal key length).
- `spi_start` out 1: to `SPI_Main.start`.
- `spi_sel` out 1: to `SPI_Main.sel`.
- `spi_tx` out [0:257]: to `SPI_Main.tx`.
- `spi_rx` in [0:127]: from `SPI_Main.rx`.
- `spi_done` in 1: from `SPI_Main.done`.
- `busy` out 1: high in any state other than IDLE.

## Operation
- Frame format: `spi_tx[0:1]` = key-length code, `spi_tx[2:257]` = payload right-aligned (LSB at bit 257), zero-filled.
- Key frame: {code, key zero-extended}. Message frame: {2'b00, data zero-extended}. Readback frame: all zeros. `rsp_data` ← `spi_rx` captured on the readback done.
- FSM: IDLE → (accept) KEY_GO → KEY_WAIT → GAP → MSG_GO → MSG_WAIT → GAP → RD_GO → RD_WAIT → RESP → IDLE.
- Illegal key length (11): go IDLE → RESP directly, with `rsp_err`=1 and no SPI activity.
- `*_GO`: `spi_start`=1 for exactly one cycle; load `spi_tx`/`spi_sel`.
- `*_WAIT`: leave on the first cycle `spi_done` is high after having been sampled low since `*_GO` (edge-qualified, so a stale done is ignored).
- GAP counts `GAP_CYCLES`, then enters the next `*_GO`.
- Timeout counter runs in every `*_WAIT`. On expiry: RESP with `rsp_err`=1, `rsp_data`=0. Remaining transfers are not issued.
- Request fields are latched at acceptance. `spi_tx` and `spi_sel` stay stable from `*_GO` until leaving `*_WAIT`.

## Timing
- Reset values: `req_ready`=1, `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, `spi_start`=0, `spi_sel`=0, `spi_tx`=0, `busy`=0. FSM is IDLE, counters are 0.
- `req_ready` = (state==IDLE). Acceptance cycle N: `spi_start` high in cycle N+1.
- Job latency = 3 transfers + 2×`GAP_CYCLES` + 3 clocks (2 transfers + 1 gap + 3 clocks on a cache hit).
- RESP: `rsp_valid` holds with stable data until `rsp_ready`. Return to IDLE the cycle after the handshake; a new request may be accepted that next cycle.
- `rst` mid-job: next cycle all outputs take their reset values. A transfer in flight in `SPI_Main` is abandoned. The cache is invalidated.

## Configuration
- `AES_SEQ_KEY_CACHE_EN` defined:
  - One entry per slave: {valid, key_len, key}, written on a successful key-frame done.
  - A job whose sel/key_len/key match a valid entry skips KEY_GO/KEY_WAIT/GAP and goes IDLE → MSG_GO.
  - An error invalidates the target slave's entry.
- Undefined: no cache storage; every job sends the key frame.

## Test plan
- Decrypt on slave 0, key 000102…0f (len 00), data 69c4e0d86a7b0430d8cdb78070b4c55a → `rsp_data` 00112233445566778899aabbccddeeff, `rsp_err`=0, exactly 3 `spi_start` pulses, `spi_tx[0:1]`=00.
- 192-bit key 000102…1617 (len 01), data dda97ca4864cdfe06eaf70a0ec0d7191 → 00112233…eeff; key frame `spi_tx[0:1]`=01.
- 256-bit key 000102…1e1f (len 10), data 8ea2b7ca516745bfeafc49904b496089 → 00112233…eeff. Repeat with the same key: cache on gives 2 `spi_start` pulses and the same result; cache off gives 3.
- `req_key_len`=11 → `rsp_valid` within 2 cycles, `rsp_err`=1, `rsp_data`=0, no `spi_start`.
- `spi_done` held low, `TIMEOUT_CYCLES`=64 → `rsp_err`=1 exactly 64 cycles after `spi_start`. With cache on, the next same-key job sends its key frame.
- `rst` asserted during MSG_WAIT → next cycle `busy`=0, `req_ready`=1, `spi_start`=0. A following job completes with correct data and 3 transfers.
